// File: rtl/ptc_input_conditioner_if.sv
// Pin-side and timer-side signals of the PTC input conditioner, grouped as one bus.
interface ptc_input_conditioner_if #(
    parameter int unsigned FILT_W  = 4,
    parameter int unsigned PRESC_W = 8
);
    logic               eclk_i;
    logic               capt_i;
    logic               enable;
    logic [FILT_W-1:0]  filt_len;
    logic [PRESC_W-1:0] presc;
    logic               eclk_o;
    logic               capt_o;
    logic               eclk_rise;
    logic               capt_rise;
    logic               capt_fall;

    // Driver of pins and configuration; consumer of conditioned outputs
    modport master (
        output eclk_i, capt_i, enable, filt_len, presc,
        input  eclk_o, capt_o, eclk_rise, capt_rise, capt_fall
    );

    // The conditioner itself
    modport slave (
        input  eclk_i, capt_i, enable, filt_len, presc,
        output eclk_o, capt_o, eclk_rise, capt_rise, capt_fall
    );
endinterface

// File: rtl/ptc_input_conditioner.sv
// PTC input conditioner: synchronises, glitch-filters and edge-detects the
// external clock and capture pins, and divides the filtered external clock.
module ptc_input_conditioner #(
    parameter int unsigned FILT_W  = 4,
    parameter int unsigned PRESC_W = 8
) (
    input  logic                     clk,
    input  logic                     rst,
    ptc_input_conditioner_if.slave   bus
);

    logic [1:0]         r_eclk_sync;
    logic [1:0]         r_capt_sync;
    logic               r_fe;
    logic               r_fc;
    logic [FILT_W-1:0]  r_ce;
    logic [FILT_W-1:0]  r_cc;
    logic               r_fe_d;
    logic               r_fc_d;
    logic [PRESC_W-1:0] r_p;
    logic               r_eclk_o;

    logic               w_fe_nxt;
    logic               w_fc_nxt;
    logic [FILT_W-1:0]  w_ce_nxt;
    logic [FILT_W-1:0]  w_cc_nxt;
    logic [PRESC_W-1:0] w_p_nxt;
    logic               w_eclk_o_nxt;
    logic               w_eclk_rise;

    // Strobes come only from flops: high in the first cycle the filtered level changes
    assign w_eclk_rise   = r_fe & ~r_fe_d;
    assign bus.eclk_rise = w_eclk_rise;
    assign bus.capt_rise = r_fc & ~r_fc_d;
    assign bus.capt_fall = ~r_fc & r_fc_d;
    assign bus.capt_o    = r_fc;
    assign bus.eclk_o    = r_eclk_o;

    // eclk glitch filter: accept a new level after filt_len+1 differing samples
    always_comb begin
        w_fe_nxt = r_fe;
        w_ce_nxt = r_ce;
        if (r_eclk_sync[1] == r_fe) begin
            w_ce_nxt = '0;
        end else if (r_ce >= bus.filt_len) begin
            w_fe_nxt = r_eclk_sync[1];
            w_ce_nxt = '0;
        end else begin
            w_ce_nxt = r_ce + FILT_W'(1);
        end
    end

    // capt glitch filter, same rule as eclk
    always_comb begin
        w_fc_nxt = r_fc;
        w_cc_nxt = r_cc;
        if (r_capt_sync[1] == r_fc) begin
            w_cc_nxt = '0;
        end else if (r_cc >= bus.filt_len) begin
            w_fc_nxt = r_capt_sync[1];
            w_cc_nxt = '0;
        end else begin
            w_cc_nxt = r_cc + FILT_W'(1);
        end
    end

    // Prescaler: >= compare lets a lowered reload wrap on the next filtered edge
    always_comb begin
        w_p_nxt      = r_p;
        w_eclk_o_nxt = r_eclk_o;
        if (!bus.enable) begin
            w_p_nxt      = '0;
            w_eclk_o_nxt = 1'b0;
        end else if (w_eclk_rise) begin
            if (r_p >= bus.presc) begin
                w_p_nxt      = '0;
                w_eclk_o_nxt = ~r_eclk_o;
            end else begin
                w_p_nxt = r_p + PRESC_W'(1);
            end
        end
    end

    // State registers; reset clears everything so outputs drop at once
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_eclk_sync <= '0;
            r_capt_sync <= '0;
            r_fe        <= 1'b0;
            r_fc        <= 1'b0;
            r_ce        <= '0;
            r_cc        <= '0;
            r_fe_d      <= 1'b0;
            r_fc_d      <= 1'b0;
            r_p         <= '0;
            r_eclk_o    <= 1'b0;
        end else begin
            r_eclk_sync <= {r_eclk_sync[0], bus.eclk_i};
            r_capt_sync <= {r_capt_sync[0], bus.capt_i};
            r_fe        <= w_fe_nxt;
            r_fc        <= w_fc_nxt;
            r_ce        <= w_ce_nxt;
            r_cc        <= w_cc_nxt;
            r_fe_d      <= r_fe;
            r_fc_d      <= r_fc;
            r_p         <= w_p_nxt;
            r_eclk_o    <= w_eclk_o_nxt;
        end
    end

endmodule

// File: tb/tb_ptc_input_conditioner.sv
// Directed bench for ptc_input_conditioner with hand-computed expectations.
module tb_ptc_input_conditioner;

    logic clk;
    logic rst;
    int   n_vec;
    int   n_err;

    ptc_input_conditioner_if #(.FILT_W(4), .PRESC_W(8)) bus ();

    ptc_input_conditioner #(.FILT_W(4), .PRESC_W(8)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Advance one clock; land 1 time unit after the rising edge
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // One 8-cycle eclk pin period (4 high, 4 low). With filt_len=0 the
    // filtered rise appears 3 edges after the pin rise and eclk_o updates
    // on the following edge.
    task automatic eclk_window(input string tag, input logic exp_o);
        bus.eclk_i = 1'b1;
        for (int t = 1; t <= 8; t++) begin
            tick();
            if (t == 3) chk({tag, "_rise"}, 32'(bus.eclk_rise), 32'd1);
            if (t == 4) begin
                chk({tag, "_rise_end"}, 32'(bus.eclk_rise), 32'd0);
                chk({tag, "_eclk_o"}, 32'(bus.eclk_o), 32'(exp_o));
                bus.eclk_i = 1'b0;
            end
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        n_vec        = 0;
        n_err        = 0;
        rst          = 1'b1;
        bus.eclk_i   = 1'b0;
        bus.capt_i   = 1'b0;
        bus.enable   = 1'b1;
        bus.filt_len = 4'd0;
        bus.presc    = 8'd0;

        // Reset held while pins toggle: every output stays 0
        for (int i = 0; i < 6; i++) begin
            bus.eclk_i = ~bus.eclk_i;
            bus.capt_i = ~bus.capt_i;
            tick();
        end
        chk("rst_eclk_o",    32'(bus.eclk_o),    32'd0);
        chk("rst_capt_o",    32'(bus.capt_o),    32'd0);
        chk("rst_eclk_rise", 32'(bus.eclk_rise), 32'd0);
        chk("rst_capt_rise", 32'(bus.capt_rise), 32'd0);
        chk("rst_capt_fall", 32'(bus.capt_fall), 32'd0);

        bus.eclk_i = 1'b0;
        bus.capt_i = 1'b0;
        tick();
        rst = 1'b0;
        tick();
        tick();
        tick();

        // filt_len=0: capt_o rises exactly 3 cycles after the pin
        bus.capt_i = 1'b1;
        tick();
        chk("lat0_c1", 32'(bus.capt_o), 32'd0);
        tick();
        chk("lat0_c2", 32'(bus.capt_o), 32'd0);
        tick();
        chk("lat0_c3_level", 32'(bus.capt_o),    32'd1);
        chk("lat0_c3_rise",  32'(bus.capt_rise), 32'd1);
        tick();
        chk("lat0_c4_rise",  32'(bus.capt_rise), 32'd0);
        chk("lat0_c4_level", 32'(bus.capt_o),    32'd1);

        // Falling edge with filt_len=0
        bus.capt_i = 1'b0;
        tick();
        tick();
        tick();
        chk("fall0_level", 32'(bus.capt_o),    32'd0);
        chk("fall0_fall",  32'(bus.capt_fall), 32'd1);
        tick();
        chk("fall0_fall_end", 32'(bus.capt_fall), 32'd0);

        // filt_len=3: a 3-cycle pulse is rejected
        bus.filt_len = 4'd3;
        bus.capt_i   = 1'b1;
        for (int t = 1; t <= 10; t++) begin
            tick();
            if (t == 3) bus.capt_i = 1'b0;
            chk("glitch_level", 32'(bus.capt_o),    32'd0);
            chk("glitch_rise",  32'(bus.capt_rise), 32'd0);
        end

        // filt_len=3: a 4-cycle pulse passes, 6 cycles after the pin edge
        bus.capt_i = 1'b1;
        tick();
        tick();
        tick();
        tick();
        bus.capt_i = 1'b0;
        tick();
        chk("pass_c5_level", 32'(bus.capt_o), 32'd0);
        tick();
        chk("pass_c6_level", 32'(bus.capt_o),    32'd1);
        chk("pass_c6_rise",  32'(bus.capt_rise), 32'd1);
        tick();
        tick();
        tick();
        chk("pass_c9_level", 32'(bus.capt_o),    32'd1);
        chk("pass_c9_fall",  32'(bus.capt_fall), 32'd0);
        tick();
        chk("pass_c10_level", 32'(bus.capt_o),    32'd0);
        chk("pass_c10_fall",  32'(bus.capt_fall), 32'd1);

        // presc=2: eclk_o toggles on every 3rd filtered rising edge
        bus.filt_len = 4'd0;
        bus.presc    = 8'd2;
        eclk_window("p2_w1", 1'b0);
        eclk_window("p2_w2", 1'b0);
        eclk_window("p2_w3", 1'b1);
        eclk_window("p2_w4", 1'b1);
        eclk_window("p2_w5", 1'b1);
        eclk_window("p2_w6", 1'b0);

        // presc=0: divide by 2
        bus.presc = 8'd0;
        eclk_window("p0_w1", 1'b1);
        eclk_window("p0_w2", 1'b0);
        eclk_window("p0_w3", 1'b1);
        eclk_window("p0_w4", 1'b0);

        // presc=5 counted to p=4, then lowered to 1: wrap on next edge
        bus.presc = 8'd5;
        eclk_window("mid_w1", 1'b0);
        eclk_window("mid_w2", 1'b0);
        eclk_window("mid_w3", 1'b0);
        eclk_window("mid_w4", 1'b0);
        bus.presc = 8'd1;
        eclk_window("mid_wrap", 1'b1);
        eclk_window("mid_p1",   1'b1);
        eclk_window("mid_p0",   1'b0);

        // Reach eclk_o=1 with p=1, then drop enable
        eclk_window("en_w1", 1'b0);
        eclk_window("en_w2", 1'b1);
        eclk_window("en_w3", 1'b1);
        bus.enable = 1'b0;
        chk("dis_before_edge", 32'(bus.eclk_o), 32'd1);
        tick();
        chk("dis_next_cycle", 32'(bus.eclk_o), 32'd0);
        eclk_window("dis_w", 1'b0);
        bus.enable = 1'b1;
        eclk_window("reen_w1", 1'b0);
        eclk_window("reen_w2", 1'b1);

        // Async reset in the middle of a capture filter count
        bus.capt_i = 1'b1;
        tick();
        tick();
        tick();
        chk("ar_capt_pre", 32'(bus.capt_o), 32'd1);
        bus.filt_len = 4'd7;
        bus.capt_i   = 1'b0;
        tick();
        tick();
        tick();
        tick();
        chk("ar_capt_mid", 32'(bus.capt_o), 32'd1);
        chk("ar_eclk_pre", 32'(bus.eclk_o), 32'd1);
        #2;
        rst = 1'b1;
        #1;
        chk("ar_capt_o", 32'(bus.capt_o),    32'd0);
        chk("ar_eclk_o", 32'(bus.eclk_o),    32'd0);
        chk("ar_rise",   32'(bus.capt_rise), 32'd0);
        chk("ar_fall",   32'(bus.capt_fall), 32'd0);
        tick();
        rst = 1'b0;
        for (int t = 0; t < 12; t++) tick();
        chk("ar_post_capt", 32'(bus.capt_o),    32'd0);
        chk("ar_post_fall", 32'(bus.capt_fall), 32'd0);
        chk("ar_post_eclk", 32'(bus.eclk_o),    32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
